// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard detection at the ID/EXE boundary: combinational stall,
// registered per-operand forwarding selects, and a saturating stall counter.
module forward_hazard_unit #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_forwarding,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] ID_src,
    input  logic [NUM_SRC-1:0]        ID_src_valid,
    input  logic                      EXE_wb_en,
    input  logic                      EXE_mem_read,
    input  logic [REG_AW-1:0]         EXE_dst,
    input  logic                      MEM_wb_en,
    input  logic                      WB_wb_en,
    input  logic [REG_AW-1:0]         MEM_dst,
    input  logic [REG_AW-1:0]         WB_dst,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      sel_src,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic                      state_stall
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    state_t                 state_q;
    logic [NUM_SRC*2-1:0]   sel_src_q;
    logic [NUM_SRC*2-1:0]   sel_src_d;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       stall_cnt_d;
    logic [NUM_SRC-1:0]     match_exe_s;
    logic [NUM_SRC-1:0]     match_mem_s;
    logic                   hazard_s;

    // Per-operand dependency matches against the EXE and MEM destinations.
    // WB is deliberately not compared: the register file write-through covers it.
    always_comb begin
        match_exe_s = '0;
        match_mem_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            match_exe_s[i] = ID_src_valid[i] & EXE_wb_en &
                             (EXE_dst == ID_src[i*REG_AW +: REG_AW]);
            match_mem_s[i] = ID_src_valid[i] & MEM_wb_en &
                             (MEM_dst == ID_src[i*REG_AW +: REG_AW]);
        end
    end

    // Raw hazard, then stall masked by flush/freeze; next-cycle select encoding.
    always_comb begin
        sel_src_d = '0;
        if (en_forwarding) begin
            hazard_s = EXE_mem_read & (|match_exe_s);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (match_exe_s[i] && !EXE_mem_read) begin
                    sel_src_d[2*i +: 2] = SEL_MEM;
                end else if (match_mem_s[i]) begin
                    sel_src_d[2*i +: 2] = SEL_WB;
                end else begin
                    sel_src_d[2*i +: 2] = SEL_RF;
                end
            end
        end else begin
            hazard_s = (|match_exe_s) | (|match_mem_s);
        end
        stall = hazard_s & ~flush & ~freeze;
    end

    // Saturating increment of the stall counter.
    always_comb begin
        if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, select and counter registers with reset > freeze > flush > stall priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_src_q   <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else if (freeze) begin
            sel_src_q   <= sel_src_q;
            state_q     <= state_q;
            stall_cnt_q <= stall_cnt_q;
        end else if (flush) begin
            sel_src_q   <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= stall_cnt_q;
        end else begin
            case (state_q)
                ST_RUN:   state_q <= stall ? ST_STALL : ST_RUN;
                ST_STALL: state_q <= stall ? ST_STALL : ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
            if (stall) begin
                sel_src_q   <= '0;
                stall_cnt_q <= stall_cnt_d;
            end else begin
                sel_src_q   <= sel_src_d;
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign sel_src     = sel_src_q;
    assign stall_cnt   = stall_cnt_q;
    assign state_stall = (state_q == ST_STALL);

endmodule
